// File: rtl/data_memory_stage_if.sv
// Request/response bundle between the MEM-stage pipeline control and the data memory.
// Latency: none (wires only). Backpressure: requester holds the request until mem_ready.
// DATAMEM_BYTEWR_EN adds the byte_en store lane mask.
interface data_memory_stage_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
`ifdef DATAMEM_BYTEWR_EN
   logic [3:0]  byte_en;
`endif
   logic [31:0] read_data;
   logic        mem_ready;
   logic        mem_busy;
   logic        addr_error;

   modport master (
`ifdef DATAMEM_BYTEWR_EN
      output byte_en,
`endif
      output mem_read, mem_write, address, write_data,
      input  read_data, mem_ready, mem_busy, addr_error
   );

   modport slave (
`ifdef DATAMEM_BYTEWR_EN
      input  byte_en,
`endif
      input  mem_read, mem_write, address, write_data,
      output read_data, mem_ready, mem_busy, addr_error
   );
endinterface

// File: rtl/data_memory_stage.sv
// Word-organised MIPS data memory with wait-state FSM; DATAMEM_BYTEWR_EN enables byte-masked stores.
// Latency: mem_ready pulses WAIT_CYCLES+1 cycles after acceptance, 1 cycle for rejected requests.
// Backpressure: one access in flight; requester holds request until mem_ready, inputs ignored meanwhile.
module data_memory_stage #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   data_memory_stage_if.slave bus
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [IDXW-1:0] idx_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic            wr_q;
   logic [31:0]     read_data_q;
   logic            ready_q;
   logic            busy_q;
   logic            error_q;

   logic [31:0]     mem [DEPTH];

   logic            req;
   logic            req_err;
   logic [IDXW-1:0] req_idx;
   logic [29:0]     word_addr;
   logic [3:0]      req_be;

   logic            wr_en;
   logic [IDXW-1:0] wr_idx;
   logic [31:0]     wr_dat;
   logic [3:0]      wr_be;

   assign req       = bus.mem_read | bus.mem_write;
   assign word_addr = bus.address[31:2];
   assign req_idx   = bus.address[IDXW+1:2];
   assign req_err   = (bus.address[1:0] != 2'b00) ||
                      (word_addr >= 30'(DEPTH)) ||
                      (bus.mem_read && bus.mem_write);

`ifdef DATAMEM_BYTEWR_EN
   assign req_be = bus.byte_en;
`else
   assign req_be = 4'hF;
`endif

   // Store commits on the edge that enters DONE; with zero wait states that is the accept edge.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = idx_q;
      wr_dat = wdata_q;
      wr_be  = be_q;
      if (state == S_WAIT && cnt == 4'd0 && wr_q) begin
         wr_en = 1'b1;
      end else if (WAIT_CYCLES == 0 && state == S_IDLE && bus.mem_write && !req_err) begin
         wr_en  = 1'b1;
         wr_idx = req_idx;
         wr_dat = bus.write_data;
         wr_be  = req_be;
      end
      if (reset) wr_en = 1'b0;
   end

   // Memory contents survive reset, so this array has no reset branch.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= 32'h0;
         be_q        <= 4'h0;
         wr_q        <= 1'b0;
         read_data_q <= 32'h0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  idx_q   <= req_idx;
                  wdata_q <= bus.write_data;
                  be_q    <= req_be;
                  wr_q    <= bus.mem_write;
                  busy_q  <= 1'b1;
                  if (req_err) begin
                     state   <= S_DONE;
                     ready_q <= 1'b1;
                     error_q <= 1'b1;
                  end else if (WAIT_CYCLES == 0) begin
                     state   <= S_DONE;
                     ready_q <= 1'b1;
                     if (bus.mem_read) read_data_q <= mem[req_idx];
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state   <= S_DONE;
                  ready_q <= 1'b1;
                  if (!wr_q) read_data_q <= mem[idx_q];
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               ready_q <= 1'b0;
               error_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b0;
               error_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.read_data  = read_data_q;
   assign bus.mem_ready  = ready_q;
   assign bus.mem_busy   = busy_q;
   assign bus.addr_error = error_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
// Byte-write vectors are exercised when DATAMEM_BYTEWR_EN is defined.
module tb_data_memory_stage;

   logic clk;
   logic reset;
   int   vec_cnt;
   int   err_cnt;

   data_memory_stage_if bus_a ();
   data_memory_stage_if bus_b ();

   data_memory_stage #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   data_memory_stage #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on the WAIT_CYCLES=2 instance; address is swapped to addr_during after acceptance.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] addr_during, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rd);
      int lat;
      bus_a.mem_read   = rd;
      bus_a.mem_write  = wr;
      bus_a.address    = addr;
      bus_a.write_data = wdata;
`ifdef DATAMEM_BYTEWR_EN
      bus_a.byte_en    = be;
`else
      if (be == 4'h0) bus_a.write_data = wdata;
`endif
      tick();
      lat = 1;
      chk({tag, ".busy"}, {31'h0, bus_a.mem_busy}, 32'h1);
      bus_a.address    = addr_during;
      bus_a.write_data = ~wdata;
      while (!bus_a.mem_ready && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".err"}, {31'h0, bus_a.addr_error}, {31'h0, exp_err});
      chk({tag, ".rdata"}, bus_a.read_data, exp_rd);
      bus_a.mem_read  = 1'b0;
      bus_a.mem_write = 1'b0;
      tick();
      chk({tag, ".ready_after"}, {30'h0, bus_a.mem_ready, bus_a.mem_busy}, 32'h0);
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      reset = 1'b1;
      bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0;
      bus_a.address = 32'h0; bus_a.write_data = 32'h0;
      bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0;
      bus_b.address = 32'h0; bus_b.write_data = 32'h0;
`ifdef DATAMEM_BYTEWR_EN
      bus_a.byte_en = 4'hF;
      bus_b.byte_en = 4'hF;
`endif
      #12;
      chk("rst.rdata", bus_a.read_data, 32'h0);
      chk("rst.ready", {31'h0, bus_a.mem_ready}, 32'h0);
      chk("rst.busy", {31'h0, bus_a.mem_busy}, 32'h0);
      chk("rst.err", {31'h0, bus_a.addr_error}, 32'h0);
      tick();
      reset = 1'b0;
      tick();

      access("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h10, 3, 1'b0, 32'h0);
      access("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h10, 3, 1'b0, 32'hDEADBEEF);
      access("ld13", 1'b1, 1'b0, 32'h13, 32'h0, 4'hF, 32'h13, 1, 1'b1, 32'hDEADBEEF);

      access("st00", 1'b0, 1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0, 3, 1'b0, 32'hDEADBEEF);
      access("st400", 1'b0, 1'b1, 32'h400, 32'h22222222, 4'hF, 32'h400, 1, 1'b1, 32'hDEADBEEF);
      access("ld00", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 3, 1'b0, 32'h11111111);

      access("st20", 1'b0, 1'b1, 32'h20, 32'h33333333, 4'hF, 32'h20, 3, 1'b0, 32'h11111111);
      access("rw20", 1'b1, 1'b1, 32'h20, 32'h44444444, 4'hF, 32'h20, 1, 1'b1, 32'h11111111);
      access("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h20, 3, 1'b0, 32'h33333333);

      // Store to 0x30 aborted by reset while in WAIT.
      access("st30", 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 32'h30, 3, 1'b0, 32'h33333333);
      bus_a.mem_write  = 1'b1;
      bus_a.address    = 32'h30;
      bus_a.write_data = 32'h12345678;
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("midrst.rdata", bus_a.read_data, 32'h0);
      chk("midrst.flags", {29'h0, bus_a.mem_ready, bus_a.mem_busy, bus_a.addr_error}, 32'h0);
      bus_a.mem_write = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      access("ld30", 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h30, 3, 1'b0, 32'hA5A5A5A5);

      access("ldtog", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h20, 3, 1'b0, 32'hDEADBEEF);

`ifdef DATAMEM_BYTEWR_EN
      access("bwff", 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h40, 3, 1'b0, 32'hDEADBEEF);
      access("bw05", 1'b0, 1'b1, 32'h40, 32'h00000000, 4'b0101, 32'h40, 3, 1'b0, 32'hDEADBEEF);
      access("bwld", 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h40, 3, 1'b0, 32'hFF00FF00);
      access("bw00", 1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0000, 32'h40, 3, 1'b0, 32'hFF00FF00);
      access("bwld2", 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h40, 3, 1'b0, 32'hFF00FF00);
`endif

      // Zero-wait-state instance: completion in the cycle right after acceptance.
      bus_b.mem_write  = 1'b1;
      bus_b.address    = 32'h8;
      bus_b.write_data = 32'h55AA55AA;
      tick();
      chk("w0.st.ready", {30'h0, bus_b.mem_ready, bus_b.addr_error}, 32'h2);
      bus_b.mem_write = 1'b0;
      tick();
      bus_b.mem_read = 1'b1;
      tick();
      chk("w0.ld.ready", {30'h0, bus_b.mem_ready, bus_b.addr_error}, 32'h2);
      chk("w0.ld.rdata", bus_b.read_data, 32'h55AA55AA);
      bus_b.mem_read = 1'b0;
      tick();
      chk("w0.idle", {30'h0, bus_b.mem_ready, bus_b.mem_busy}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
